// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared constants and helpers for the multiplexed 7-segment
//             scanner: blank levels, hex glyphs, frame record, slot map.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // All anodes released / all segments dark (both active-low).
    localparam logic [7:0] c_an_blank  = 8'hFF;
    localparam logic [6:0] c_seg_blank = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] c_glyph_0 = 7'b1000000;
    localparam logic [6:0] c_glyph_1 = 7'b1111001;
    localparam logic [6:0] c_glyph_2 = 7'b0100100;
    localparam logic [6:0] c_glyph_3 = 7'b0110000;
    localparam logic [6:0] c_glyph_4 = 7'b0011001;
    localparam logic [6:0] c_glyph_5 = 7'b0010010;
    localparam logic [6:0] c_glyph_6 = 7'b0000010;
    localparam logic [6:0] c_glyph_7 = 7'b1111000;
    localparam logic [6:0] c_glyph_8 = 7'b0000000;
    localparam logic [6:0] c_glyph_9 = 7'b0010000;
    localparam logic [6:0] c_glyph_a = 7'b0001000;
    localparam logic [6:0] c_glyph_b = 7'b0000011;
    localparam logic [6:0] c_glyph_c = 7'b1000110;
    localparam logic [6:0] c_glyph_d = 7'b0100001;
    localparam logic [6:0] c_glyph_e = 7'b0000110;
    localparam logic [6:0] c_glyph_f = 7'b0001110;

    // Snapshot of the display inputs taken once per frame.
    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic [3:0] d4;
    } frame_t;

    localparam frame_t c_frame_reset = '{mask: 8'hFF, d1: 4'h0, d2: 4'h0, d3: 4'h0, d4: 4'h0};

    // Slot-to-nibble map: slots 0,1,4,5 carry d4,d3,d2,d1; the rest show zero.
    function automatic logic [3:0] slot_nibble(input logic [2:0] slot, input frame_t fr);
        logic [3:0] nib;
        nib = 4'h0;
        case (slot)
            3'd0:    nib = fr.d4;
            3'd1:    nib = fr.d3;
            3'd4:    nib = fr.d2;
            3'd5:    nib = fr.d1;
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_seg7
//  Brief    : Combinational hex nibble to active-low 7-segment glyph decode.
//  Revision : 1.0  initial release
// ============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Plain lookup of the sixteen hex glyphs.
    always_comb begin
        seg = c_seg_blank;
        case (nibble)
            4'h0: seg = c_glyph_0;
            4'h1: seg = c_glyph_1;
            4'h2: seg = c_glyph_2;
            4'h3: seg = c_glyph_3;
            4'h4: seg = c_glyph_4;
            4'h5: seg = c_glyph_5;
            4'h6: seg = c_glyph_6;
            4'h7: seg = c_glyph_7;
            4'h8: seg = c_glyph_8;
            4'h9: seg = c_glyph_9;
            4'hA: seg = c_glyph_a;
            4'hB: seg = c_glyph_b;
            4'hC: seg = c_glyph_c;
            4'hD: seg = c_glyph_d;
            4'hE: seg = c_glyph_e;
            4'hF: seg = c_glyph_f;
            default: seg = c_seg_blank;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan
//  Brief    : Eight-slot multiplexed 7-segment scanner with per-slot dead
//             time, frame-latched inputs and registered outputs.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] anodo,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  c_last  = PW'(DIV - 1);
    localparam logic [PW-1:0]  c_blank = PW'(BLANK);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q,   idx_d;
    frame_t        frame_q, frame_d;
    logic [7:0]    an_q,    an_d;
    logic [6:0]    seg_q,   seg_d;
    logic          fs_q,    fs_d;

    logic          w_wrap;
    logic          w_load;
    logic [3:0]    w_nib;
    logic [6:0]    w_glyph;

    // Glyph of the nibble belonging to the slot currently being scanned.
    hex_to_seg7 u_glyph (
        .nibble (w_nib),
        .seg    (w_glyph)
    );

    // Next-state logic: prescaler, slot index, frame snapshot and output image.
    // The output image uses frame_d so the cycle that loads a new frame
    // already decodes the new contents.
    always_comb begin
        w_wrap  = (presc_q == c_last);
        presc_d = w_wrap ? '0 : presc_q + 1'b1;
        idx_d   = w_wrap ? idx_q + 3'd1 : idx_q;
        w_load  = (presc_q == '0) && (idx_q == 3'd0);
        frame_d = w_load ? frame_t'{mask: anodo, d1: d1, d2: d2, d3: d3, d4: d4} : frame_q;
        fs_d    = w_load;
        w_nib   = slot_nibble(idx_q, frame_d);
        an_d    = c_an_blank;
        seg_d   = c_seg_blank;
        if ((presc_q >= c_blank) && !frame_d.mask[idx_q]) begin
            an_d  = ~(8'b0000_0001 << idx_q);
            seg_d = w_glyph;
        end
    end

    // State and output registers; reset blanks the display asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            frame_q <= c_frame_reset;
            an_q    <= c_an_blank;
            seg_q   <= c_seg_blank;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = 1'b1;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan
//  Brief    : Scoreboard bench for seg7_scan with DIV=8, BLANK=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] anodo;
    logic [3:0] d1, d2, d3, d4;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp, frame_start;

    always #5 clk = ~clk;

    seg7_scan #(.DIV(8), .BLANK(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .anodo       (anodo),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .d4          (d4),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_samp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    // Expand a hand-written per-slot table (slot 0 in the low bits) into one
    // expected entry per clock: dead time for prescaler 0..1, slot image after.
    task automatic push_frame(input logic [63:0] an_tab, input logic [55:0] seg_tab, input int n);
        for (int t = 0; t < n; t++) begin
            exp_t e;
            int   s;
            int   p;
            s = t / 8;
            p = t % 8;
            if (p < 2) begin
                e.an  = 8'hFF;
                e.seg = 7'h7F;
            end else begin
                e.an  = an_tab[8*s +: 8];
                e.seg = seg_tab[7*s +: 7];
            end
            e.fs = (t == 0);
            sb.push_back(e);
        end
    endtask

    // Monitor: one expected entry per sampled output cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n) check("an_at_most_one_low", 32'($countones(~an) <= 1), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("an[%0d]", n_samp), 32'(an), 32'(e.an));
            check($sformatf("seg[%0d]", n_samp), 32'(seg), 32'(e.seg));
            check($sformatf("frame_start[%0d]", n_samp), 32'(frame_start), 32'(e.fs));
            check($sformatf("dp[%0d]", n_samp), 32'(dp), 32'd1);
            n_samp++;
        end
    end

    logic [63:0] an_a, an_b, an_off;
    logic [55:0] seg_a, seg_b, seg_c, seg_d, seg_off;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        an_a    = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE};
        seg_a   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0011001, 7'b0100100};
        an_b    = {8'hFF, 8'hFF, 8'hDF, 8'hEF, 8'hFF, 8'hFF, 8'hFD, 8'hFE};
        seg_b   = {7'h7F, 7'h7F, 7'b0001110, 7'b0000110, 7'h7F, 7'h7F, 7'b1000000, 7'b0000000};
        seg_c   = seg_b;
        seg_c[6:0] = 7'b0100100;
        seg_d   = seg_b;
        seg_d[6:0] = 7'b1111000;
        an_off  = {8{8'hFF}};
        seg_off = {8{7'h7F}};

        anodo = 8'hFC; d1 = 4'h0; d2 = 4'h0; d3 = 4'h4; d4 = 4'h2;
        reset_n = 1'b0;
        step(3);
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'd1);
        check("reset_frame_start", 32'(frame_start), 32'd0);

        #1 reset_n = 1'b1;
        push_frame(an_a, seg_a, 64);
        push_frame(an_b, seg_b, 64);
        step(20);                                    // t=20, frame 1 slot 2
        anodo = 8'hCC; d1 = 4'hF; d2 = 4'hE; d3 = 4'h0; d4 = 4'h8;
        step(64);                                    // t=84, frame 2
        push_frame(an_b, seg_c, 64);
        d4 = 4'h2;
        step(71);                                    // t=155, frame 3 slot 3
        d4 = 4'h7;
        push_frame(an_b, seg_d, 64);
        step(57);                                    // t=212, frame 4
        anodo = 8'hFF;
        push_frame(an_off, seg_off, 64);
        push_frame(an_off, seg_off, 64);
        step(128);                                   // t=340, frame 6
        anodo = 8'hCC;
        push_frame(an_b, seg_d, 37);
        step(81);                                    // t=421, frame 7 slot 4 presc 5
        #1;
        check("scoreboard_drained_before_reset", 32'(sb.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'hFF);
        check("async_reset_seg", 32'(seg), 32'h7F);
        check("async_reset_frame_start", 32'(frame_start), 32'd0);
        check("async_reset_dp", 32'(dp), 32'd1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        push_frame(an_b, seg_d, 64);
        step(64);
        #1;
        check("scoreboard_drained_at_end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
